// File: rtl/mvm_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters exclusive use of a shared
// matrix-vector multiplier. Optional BUSY watchdog enabled by defining MVM_ARB_TIMEOUT_EN.
module mvm_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       mvm_start,
    input  logic                       mvm_done,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("mvm_arbiter: NUM_REQ or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e             state;
    state_e             next_state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [NUM_REQ-1:0] owner_oh;
    logic               tmo_hit;

    // Modulo-NUM_REQ add that also works for non-power-of-two requester counts.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[wrap_add(ptr, i)]) begin
                pick  = wrap_add(ptr, i);
                found = 1'b1;
            end
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) begin
                owner <= pick;
            end
            // The outgoing owner drops to lowest priority for the next arbitration.
            if (state == RELEASE) begin
                ptr <= wrap_add(owner, 1);
            end
        end
    end

    always_comb begin
        next_state = state;
        grant      = '0;
        grant_idx  = '0;
        req_done   = '0;
        mvm_start  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = BUSY;
                mvm_start  = 1'b1;
                busy       = 1'b1;
                grant      = owner_oh;
                grant_idx  = owner;
            end
            BUSY: begin
                if (mvm_done || tmo_hit) begin
                    next_state = RELEASE;
                end
                busy      = 1'b1;
                grant     = owner_oh;
                grant_idx = owner;
            end
            RELEASE: begin
                next_state = IDLE;
                busy       = 1'b1;
                grant      = owner_oh;
                grant_idx  = owner;
                req_done   = owner_oh;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef MVM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_flag;

    assign tmo_hit = (state == BUSY) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // mvm_done on the final BUSY cycle wins over the watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            tmo_flag <= tmo_hit && !mvm_done;
        end
    end

    assign timeout_err = (state == RELEASE && tmo_flag) ? owner_oh : '0;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_mvm_arbiter.sv
// Scoreboard bench for mvm_arbiter: the driver plans each tenure's timeline from the
// arbitration rules and queues it; a negedge monitor checks every output every cycle.
module tb_mvm_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 8;
`ifdef MVM_ARB_TIMEOUT_EN
    localparam int DMAX = TMO + 4;
`else
    localparam int DMAX = 6;
`endif

    typedef struct {
        int w;
        int start;
        int rel;
        bit to;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req = '0;
    logic          mvm_done = 1'b0;
    logic [NR-1:0] grant;
    logic [1:0]    grant_idx;
    logic [NR-1:0] req_done;
    logic          mvm_start;
    logic          busy;
    logic [NR-1:0] timeout_err;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   abort_cyc = -1;
    int   ptr_m = 0;
    int   n_done_exp = 0;
    int   n_done_seen = 0;
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    txn_t cur;
    txn_t exp_q[$];

    mvm_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .req_done   (req_done),
        .mvm_start  (mvm_start),
        .mvm_done   (mvm_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present r in the current IDLE cycle; multiplier finishes d cycles after start.
    task automatic run_txn(input logic [NR-1:0] r, input int d, input bit noise);
        int w;
        int p0;
        int rel;
        bit to;
        req      = r;
        mvm_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        p0       = cyc;
        w        = rr_pick(r, ptr_m);
        to       = 1'b0;
        rel      = p0 + 2 + d;
`ifdef MVM_ARB_TIMEOUT_EN
        if (d > TMO) begin
            to  = 1'b1;
            rel = p0 + 2 + TMO;
        end
`endif
        exp_q.push_back('{w, p0 + 1, rel, to});
        ptr_m = (w + 1) % NR;
        step();
        if (noise) begin
            req      = NR'($urandom);
            mvm_done = 1'($urandom_range(0, 1));
        end
        while (cyc < rel) begin
            step();
            mvm_done = !to && (cyc == p0 + 1 + d);
            if (noise) req = NR'($urandom);
        end
        if (noise) mvm_done = 1'($urandom_range(0, 1));
        step();
        req      = '0;
        mvm_done = 1'b0;
        n_done_exp++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            req      = '0;
            mvm_done = 1'($urandom_range(0, 1));
        end
    endtask

    // Start a tenure for requester 2 and reset the arbiter in the middle of BUSY.
    task automatic abort_test();
        req      = 4'b0100;
        mvm_done = 1'b0;
        exp_q.push_back('{rr_pick(req, ptr_m), cyc + 1, cyc + 1000, 1'b0});
        step();
        step();
        step();
        reset     = 1'b0;
        abort_cyc = cyc + 1;
        req       = NR'($urandom);
        mvm_done  = 1'b1;
        step();
        reset    = 1'b1;
        req      = '0;
        mvm_done = 1'b0;
        ptr_m    = 0;
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        logic [NR-1:0] et;
        logic [1:0]    ei;
        logic          es;
        logic          eb;
        if (mon_en) begin
            if (cyc == abort_cyc) active = 1'b0;
            if (!active && exp_q.size() > 0 && exp_q[0].start == cyc) begin
                cur    = exp_q.pop_front();
                active = 1'b1;
            end
            eg = '0; ed = '0; et = '0; ei = '0; es = 1'b0; eb = 1'b0;
            if (active) begin
                eg = NR'(1) << cur.w;
                ei = 2'(cur.w);
                eb = 1'b1;
                es = (cyc == cur.start);
                if (cyc == cur.rel) begin
                    ed = eg;
                    et = cur.to ? eg : '0;
                end
            end
            n_tests++;
            if ({grant, grant_idx, mvm_start, busy, req_done, timeout_err} !==
                {eg, ei, es, eb, ed, et}) begin
                n_fail++;
                $display("FAIL cycle_%0d: got grant=%b idx=%0d start=%b busy=%b done=%b terr=%b, expected grant=%b idx=%0d start=%b busy=%b done=%b terr=%b",
                         cyc, grant, grant_idx, mvm_start, busy, req_done, timeout_err,
                         eg, ei, es, eb, ed, et);
            end
            if (req_done != '0) n_done_seen++;
            if (active && cyc == cur.rel) active = 1'b0;
        end
    end

    initial begin
        logic [NR-1:0] r;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        step();
        reset = 1'b1;

        repeat (5) run_txn(4'b1111, 3, 1'b0);
        idle(2);
        run_txn(4'b0001, 4, 1'b0);
        idle(1);
        run_txn(4'b1000, 2, 1'b0);
        run_txn(4'b1001, 2, 1'b0);
        run_txn(4'b0110, 3, 1'b1);
        run_txn(4'b0010, 1, 1'b0);
        abort_test();
        run_txn(4'b0101, 2, 1'b0);
        idle(1);
        abort_test();
        run_txn(4'b0100, 2, 1'b0);
`ifdef MVM_ARB_TIMEOUT_EN
        run_txn(4'b0010, 20, 1'b0);
        run_txn(4'b0100, TMO, 1'b0);
        run_txn(4'b1000, TMO + 1, 1'b0);
        run_txn(4'b1000, TMO - 1, 1'b1);
`endif

        for (int t = 0; t < 60; t++) begin
            idle(int'($urandom_range(0, 2)));
            r = NR'($urandom);
            if (r == '0) r = NR'(1) << $urandom_range(0, NR - 1);
            run_txn(r, int'($urandom_range(1, DMAX)), 1'b1);
        end
        idle(3);

        n_tests++;
        if (exp_q.size() != 0 || active) begin
            n_fail++;
            $display("FAIL drain: got pending=%0d active=%0b, expected pending=0 active=0",
                     exp_q.size(), active);
        end
        n_tests++;
        if (n_done_seen != n_done_exp) begin
            n_fail++;
            $display("FAIL done_count: got %0d req_done pulses, expected %0d",
                     n_done_seen, n_done_exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_arbiter.md
MVM_ARBITER -- requirements
Module: mvm_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one matrix-vector multiplier; range 2..16.
REQ-002 Parameter TIMEOUT, default 64: maximum BUSY cycles before a tenure is aborted; applies only when MVM_ARB_TIMEOUT_EN is defined; range 2..65535.
REQ-003 Port clk, input, 1: sole clock; all logic is updated on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port req, input, NUM_REQ: level request per requester, held high until that requester sees req_done.
REQ-006 Port grant, output, NUM_REQ: one-hot ownership of the multiplier; all zero when no requester owns it.
REQ-007 Port grant_idx, output, $clog2(NUM_REQ): binary index of the current owner, used as the operand-mux select.
REQ-008 Port req_done, output, NUM_REQ: one-cycle completion pulse to the owner.
REQ-009 Port mvm_start, output, 1: one-cycle start pulse to the multiplier.
REQ-010 Port mvm_done, input, 1: completion from the multiplier.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port timeout_err, output, NUM_REQ: one-cycle abort flag to the owner.

Function
REQ-013 The arbiter SHALL implement four states: IDLE, START, BUSY and RELEASE.
REQ-014 IDLE: if req is nonzero, choose the winner round-robin from the pointer, register it, and go to START; otherwise stay in IDLE.
REQ-015 Round-robin: search from index ptr upward and wrap modulo NUM_REQ; the first set req bit wins.
REQ-016 START lasts exactly one cycle: mvm_start=1, grant and grant_idx are valid; the next state is BUSY.
REQ-017 Latency: req first sampled high in IDLE at cycle N gives grant and mvm_start high at cycle N+1.
REQ-018 BUSY: stay until mvm_done is sampled high, then go to RELEASE; mvm_done is ignored outside BUSY.
REQ-019 RELEASE lasts one cycle: req_done[owner]=1 and grant is still held; ptr becomes (owner+1) mod NUM_REQ; the next state is IDLE.
REQ-020 grant and grant_idx SHALL be held constant from START through RELEASE; grant is zero in IDLE, and grant_idx is 0 in IDLE.
REQ-021 req changes during START/BUSY/RELEASE, including the owner dropping req, SHALL NOT abort or alter the current tenure.
REQ-022 In IDLE after RELEASE, req is re-arbitrated; the previous owner has the lowest priority. The minimum tenure is 4 cycles including the IDLE cycle.
REQ-023 mvm_start SHALL never be asserted while busy is asserted outside START, so at most one operation is outstanding.
REQ-024 timeout_err is constant 0 unless MVM_ARB_TIMEOUT_EN is defined.

Reset
REQ-025 When reset=0 at a clock edge: state=IDLE, ptr=0, grant=0, grant_idx=0, req_done=0, mvm_start=0, busy=0, timeout_err=0, timeout counter=0.
REQ-026 A reset in any state, including mid-tenure, SHALL abandon the tenure with no req_done pulse; the multiplier is reset by its own reset.

Configuration
REQ-027 With MVM_ARB_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each BUSY cycle.
REQ-028 Under MVM_ARB_TIMEOUT_EN, if the counter reaches TIMEOUT-1 without mvm_done, the next state is RELEASE with timeout_err[owner]=1 alongside req_done[owner]=1.
REQ-029 Under MVM_ARB_TIMEOUT_EN, mvm_done high on the same cycle the counter reaches TIMEOUT-1 counts as normal completion, with no timeout_err.
REQ-030 Without MVM_ARB_TIMEOUT_EN: no counter is built, BUSY waits indefinitely for mvm_done, and timeout_err is tied 0.

Verification
REQ-031 Single requester (NUM_REQ=4): req=0001 at cycle 0, mvm_done at cycle 5. Expect mvm_start and grant=0001 at cycle 1, req_done=0001 at cycle 6, busy low at cycle 7.
REQ-032 Fairness: req=1111 held, mvm_done 3 cycles after each start. Expect grant order 0001,0010,0100,1000,0001; each req_done is one cycle.
REQ-033 Pointer wrap: owner 3 completes with req=1001. Expect the next grant=0001 and grant_idx=0.
REQ-034 Reset mid-BUSY: reset=0 for 1 cycle with owner 2. Expect all outputs 0, no req_done, and with req=0100 the next grant is to index 2 with ptr=0.
REQ-035 Timeout (macro defined, TIMEOUT=8), no mvm_done. Expect req_done and timeout_err on the owner 8 cycles after BUSY entry; mvm_done at the 8th BUSY cycle gives no timeout_err.
REQ-036 Spurious mvm_done in IDLE/START, and the owner dropping req during BUSY. Expect no state change and normal completion.
